pipe_core: RTL

- Parametrised successor of the 8-bit four-stage CPU. Stages: fetch, decode, execute, writeback.
- Generalises data width, register count and program depth, and replaces the joystick loader with a clean load port.
- Adds behaviour the first generation lacks: full operand forwarding, branch flush, HALT, and a debug register read port.
- Sits below the board-level top, which maps switches/stick/LEDs onto the load, run and debug ports.

---
 rtl/core_pkg.sv | 54 +++++
 rtl/core_alu.sv | 38 +++
 rtl/core_regfile.sv | 43 ++++
 rtl/pipe_core.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for pipe_core: opcode encoding, NOP encoding and
// instruction field layout as functions of the register-address and data
// widths.
//
// Instruction layout, MSB first: {op[3:0], rd, ra, F[DATA_W-1:0]}.
package core_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_XOR   = 4'h5,
        OP_SHL   = 4'h6,
        OP_SHR   = 4'h7,
        OP_LDI   = 4'h8,
        OP_ADDI  = 4'h9,
        OP_BEQ   = 4'hA,
        OP_BGT   = 4'hB,
        OP_JMP   = 4'hC,
        OP_HALT  = 4'hD,
        OP_RSV_E = 4'hE,
        OP_RSV_F = 4'hF
    } opcode_t;

    // An all-zero word decodes as NOP in every field.
    localparam opcode_t NOP_OP = OP_NOP;

    function automatic int instr_width(int reg_aw, int data_w);
        return OP_W + 2 * reg_aw + data_w;
    endfunction

    function automatic int rd_lsb(int reg_aw, int data_w);
        return reg_aw + data_w;
    endfunction

    function automatic int ra_lsb(int data_w);
        return data_w;
    endfunction

    // ADD..ADDI are the only opcodes that write a register.
    function automatic logic op_writes(opcode_t op);
        return (op >= OP_ADD) && (op <= OP_ADDI);
    endfunction

    // Conditional branches compare R[rd] with R[ra] instead of reading rb.
    function automatic logic op_is_branch(opcode_t op);
        return (op == OP_BEQ) || (op == OP_BGT);
    endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational ALU for pipe_core.
//   op     : opcode of the instruction in execute
//   a, b   : operands (b already holds F for LDI/ADDI)
//   result : value written to rd for register-writing opcodes
//   eq, gt : a == b and unsigned a > b, used by BEQ/BGT
module core_alu
    import core_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  opcode_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              eq,
    output logic              gt
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = {a[DATA_W-2:0], 1'b0};
            OP_SHR:  result = {1'b0, a[DATA_W-1:1]};
            OP_LDI:  result = b;
            OP_ADDI: result = a + b;
            default: result = '0;
        endcase
    end

    assign eq = (a == b);
    assign gt = (a > b);

endmodule

// File: rtl/core_regfile.sv
// Register file for pipe_core: two operand read ports, one debug read port,
// one write port. Cleared by reset and by the synchronous clear input.
//   clk, rst_n          : clock, asynchronous active-low reset
//   clr                 : synchronous clear of every register (load mode)
//   we, waddr, wdata    : write port
//   raddr_a/b, rdata_a/b: combinational operand reads
//   raddr_d, rdata_d    : combinational debug read
module core_regfile #(
    parameter  int DATA_W   = 8,
    parameter  int NUM_REGS = 8,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    input  logic [REG_AW-1:0] raddr_d,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] rdata_d
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];
    assign rdata_d = regs[raddr_d];

endmodule

// File: rtl/pipe_core.sv
// pipe_core: four-stage (fetch, decode, execute, writeback) parametrised CPU
// with full operand forwarding, branch flush, HALT and a debug read port.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   run_i         : 1 = execute, 0 = load mode (core held in reset state)
//   ld_we_i, ld_addr_i, ld_data_i : program memory write port (load mode only)
//   dbg_sel_i, dbg_data_o         : combinational register read
//   pc_o          : current fetch PC
//   halted_o      : HALT has retired from execute
module pipe_core
    import core_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int NUM_REGS   = 8,
    parameter  int PMEM_DEPTH = 128,
    localparam int REG_AW     = $clog2(NUM_REGS),
    localparam int PC_W       = $clog2(PMEM_DEPTH),
    localparam int INSTR_W    = instr_width(REG_AW, DATA_W)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               run_i,
    input  logic               ld_we_i,
    input  logic [PC_W-1:0]    ld_addr_i,
    input  logic [INSTR_W-1:0] ld_data_i,
    input  logic [REG_AW-1:0]  dbg_sel_i,
    output logic [DATA_W-1:0]  dbg_data_o,
    output logic [PC_W-1:0]    pc_o,
    output logic               halted_o
);

    localparam int RD_LSB = rd_lsb(REG_AW, DATA_W);
    localparam int RA_LSB = ra_lsb(DATA_W);

    // Program memory: not reset, written only in load mode.
    logic [INSTR_W-1:0] mem [PMEM_DEPTH];

    always_ff @(posedge clk_i) begin
        if (!run_i && ld_we_i) mem[ld_addr_i] <= ld_data_i;
    end

    // started delays the first fetch by one edge after run_i rises.
    logic            started;
    logic            halted;
    logic [PC_W-1:0] pc;

    logic [INSTR_W-1:0] instr_p0;
    logic               vld_p0;

    opcode_t           op_p1;
    logic [REG_AW-1:0] rd_p1;
    logic [DATA_W-1:0] a_p1, b_p1;
    logic [PC_W-1:0]   tgt_p1;
    logic              vld_p1;

    logic [REG_AW-1:0] rd_p2;
    logic [DATA_W-1:0] res_p2;
    logic              vld_p2;

    // ---- decode: field extraction, regfile read, forwarding ----
    opcode_t           op_d;
    logic [REG_AW-1:0] rd_d, ra_d, raddr_a, raddr_b;
    logic [DATA_W-1:0] f_d, rf_a, rf_b, opnd_a, opnd_b, a_d, b_d;
    logic [DATA_W-1:0] alu_res;
    logic              alu_eq, alu_gt, ex_wr, taken, halt_ex, squash;

    assign op_d = opcode_t'(instr_p0[INSTR_W-1 -: OP_W]);
    assign rd_d = instr_p0[RD_LSB +: REG_AW];
    assign ra_d = instr_p0[RA_LSB +: REG_AW];
    assign f_d  = instr_p0[DATA_W-1:0];

    // Branches compare R[rd] against R[ra], so the ports swap roles.
    assign raddr_a = op_is_branch(op_d) ? rd_d : ra_d;
    assign raddr_b = op_is_branch(op_d) ? ra_d : f_d[REG_AW-1:0];

    core_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_regfile (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .clr     (!run_i),
        .we      (vld_p2),
        .waddr   (rd_p2),
        .wdata   (res_p2),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .raddr_d (dbg_sel_i),
        .rdata_a (rf_a),
        .rdata_b (rf_b),
        .rdata_d (dbg_data_o)
    );

    // Later assignments win: execute result > writeback data > regfile.
    always_comb begin
        opnd_a = rf_a;
        opnd_b = rf_b;
        if (vld_p2 && rd_p2 == raddr_a) opnd_a = res_p2;
        if (vld_p2 && rd_p2 == raddr_b) opnd_b = res_p2;
        if (ex_wr && rd_p1 == raddr_a)  opnd_a = alu_res;
        if (ex_wr && rd_p1 == raddr_b)  opnd_b = alu_res;
        a_d = opnd_a;
        b_d = (op_d == OP_LDI || op_d == OP_ADDI) ? f_d : opnd_b;
    end

    // ---- execute: ALU, branch and HALT resolution ----
    core_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op_p1),
        .a      (a_p1),
        .b      (b_p1),
        .result (alu_res),
        .eq     (alu_eq),
        .gt     (alu_gt)
    );

    assign ex_wr   = vld_p1 && op_writes(op_p1);
    assign taken   = vld_p1 && ((op_p1 == OP_BEQ && alu_eq) ||
                                (op_p1 == OP_BGT && alu_gt) ||
                                (op_p1 == OP_JMP));
    assign halt_ex = vld_p1 && (op_p1 == OP_HALT);
    assign squash  = taken || halt_ex;

    // ---- control state: pc, valids, halt ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            started <= 1'b0;
            halted  <= 1'b0;
            pc      <= '0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
        end else if (!run_i) begin
            started <= 1'b0;
            halted  <= 1'b0;
            pc      <= '0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
        end else begin
            started <= 1'b1;
            vld_p2  <= ex_wr;
            if (halt_ex) halted <= 1'b1;
            if (squash) begin
                vld_p0 <= 1'b0;
                vld_p1 <= 1'b0;
            end else begin
                vld_p0 <= started && !halted;
                vld_p1 <= vld_p0;
            end
            if (taken)                                pc <= tgt_p1;
            else if (started && !halted && !halt_ex)  pc <= pc + 1'b1;
        end
    end

    // ---- pipeline data latches (qualified by the valids above) ----
    always_ff @(posedge clk_i) begin
        instr_p0 <= mem[pc];
        op_p1    <= op_d;
        rd_p1    <= rd_d;
        a_p1     <= a_d;
        b_p1     <= b_d;
        tgt_p1   <= f_d[PC_W-1:0];
        rd_p2    <= rd_p1;
        res_p2   <= alu_res;
    end

    assign pc_o     = pc;
    assign halted_o = halted;

endmodule
